bcd_to_bin: RTL and testbench
=============================

# bcd_to_bin

- Converts a four-digit BCD value (thousands, hundreds, tens, ones) back into a 12-bit binary number.
- It is the inverse of the game's binary-to-digit display converter: it turns keypad-entered or display-format digits into a binary value for comparison logic.
- The conversion is iterative multiply-by-ten accumulation, one digit per clock, most-significant digit first, with a start/busy/done handshake.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  conversion request; sampled on the rising edge
- tho  input  4  thousands BCD digit; sampled with start
- hun  input  4  hundreds BCD digit; sampled with start
- ten  input  4  tens BCD digit; sampled with start
- one  input  4  ones BCD digit; sampled with start
- binary  output  12  converted result; held until the next completion
- done  output  1  single-cycle completion pulse
- busy  output  1  high while a conversion is in progress
- ovf  output  1  result exceeded 4095 and was saturated
- err  output  1  an input digit was > 9 (only with the macro; otherwise tied 0)

## Operation
- Three states: IDLE, CONV, DONE.
- Reset (async, reset_n low):
  - State goes to IDLE and the internal counter and accumulator clear.
  - binary = 0, done = 0, busy = 0, ovf = 0, err = 0.
- IDLE, start = 1:
  - Latch all four digits into a 16-bit register.
  - Clear the 14-bit accumulator and the 2-bit digit counter.
  - Go to CONV.
- IDLE, start = 0: hold.
- CONV step on each edge: acc <= acc*10 + digit[cnt], where cnt 0..3 selects tho, hun, ten, one.
  - Implement ×10 as (acc<<3)+(acc<<1).
  - The accumulator is 14 bits wide; the maximum 9999 fits.
- After the 4th step, go to DONE and register the outputs:
  - acc ≤ 4095: binary = acc[11:0], ovf = 0.
  - acc > 4095: binary = 12'hFFF, ovf = 1.
  - err is updated per the Configuration section.
- DONE (one cycle):
  - done = 1, busy = 0.
  - Next edge: if start = 1, latch new digits and go to CONV (back-to-back); otherwise go to IDLE.
- start while in CONV is ignored; the latched digits are unaffected.
- binary, ovf and err hold their values from the completion until the next completion or reset.
- Changes on the digit inputs outside the start-sampling edge have no effect.

## Timing
- Take start = 1 at IDLE edge k:
  - busy is high from after edge k through edge k+4.
  - The conversion steps occur on edges k+1 through k+4.
  - binary, ovf, err and done update after edge k+4; done is high for exactly one cycle.
- Latency from start edge to done is 4 cycles.
- Minimum start-to-start spacing is 5 cycles, using a start during the DONE cycle.
- done and busy are never high in the same cycle.
- Reset asserted mid-CONV:
  - Aborts immediately; no done pulse.
  - binary returns to 0.
  - The first start after release begins a fresh conversion.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: BCD2BIN_DIGIT_CHECK_EN.
- Defined:
  - On the start edge, flag any latched digit > 9.
  - The conversion still runs the full 4 cycles and completes with done.
  - The flag forces binary = 0, ovf = 0, err = 1.
  - A valid conversion clears err.
- Undefined:
  - err is constant 0.
  - Digits > 9 are used arithmetically with their raw value 10..15, i.e. no check logic is synthesized.

## Test plan
- Reset, then idle 10 cycles: binary=0, done=0, busy=0, ovf=0, err=0 throughout.
- start with 4,0,9,5: busy for 4 cycles, then done pulses 4 cycles after start with binary=4095, ovf=0.
- start with 0,1,2,3, then start again in the DONE cycle with 9,9,9,9:
  - First result: binary=123.
  - Second result 5 cycles later: binary=4095, ovf=1.
- start with 1,0xA,0,0:
  - With the macro: err=1, binary=0.
  - Without the macro: err=0, binary=2000.
- start with 2,5,0,0, then at cycle 2 pulse start with 7,7,7,7 and change the digit inputs:
  - Result is binary=2500.
  - The second start is ignored.
- start with 3,3,3,3, then assert reset_n low at cycle 2:
  - binary=0, no done pulse.
  - After release, start with 0,0,0,7 gives binary=7.

Source files
------------

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: four BCD digits -> 12-bit binary via multiply-by-ten accumulation, one digit per clock, MSD first.
// Optional macro BCD2BIN_DIGIT_CHECK_EN flags digits > 9 (err=1, binary forced to 0); otherwise err is tied 0.
module bcd_to_bin (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  tho,
  input  logic [3:0]  hun,
  input  logic [3:0]  ten,
  input  logic [3:0]  one,
  output logic [11:0] binary,
  output logic        done,
  output logic        busy,
  output logic        ovf,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CONV = 2'd1, S_DONE = 2'd2} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_digits;
  logic [13:0] r_acc;
  logic [1:0]  r_cnt;
  logic [11:0] r_binary;
  logic        r_ovf;
  logic        w_load;
  logic        w_last;
  logic [3:0]  w_digit;
  logic [14:0] w_acc_ext;
  logic [14:0] w_acc_next;
  logic [11:0] w_res_bin;
  logic        w_res_ovf;

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic r_bad;
  logic r_err;
  logic w_bad;
  assign w_bad = (tho > 4'd9) || (hun > 4'd9) || (ten > 4'd9) || (one > 4'd9);
  assign err   = r_err;
`else
  assign err   = 1'b0;
`endif

  assign w_load = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last = (r_state == S_CONV) && (r_cnt == 2'd3);

  always_comb begin
    w_digit = 4'd0;
    case (r_cnt)
      2'd0:    w_digit = r_digits[15:12];
      2'd1:    w_digit = r_digits[11:8];
      2'd2:    w_digit = r_digits[7:4];
      default: w_digit = r_digits[3:0];
    endcase
  end

  // One spare bit so raw 15s on the final step cannot wrap before the saturation compare.
  assign w_acc_ext  = {1'b0, r_acc};
  assign w_acc_next = (w_acc_ext << 3) + (w_acc_ext << 1) + {11'd0, w_digit};

  always_comb begin
    w_res_ovf = (w_acc_next > 15'd4095);
    w_res_bin = w_res_ovf ? 12'hFFF : w_acc_next[11:0];
`ifdef BCD2BIN_DIGIT_CHECK_EN
    if (r_bad) begin
      w_res_ovf = 1'b0;
      w_res_bin = 12'd0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = start ? S_CONV : S_IDLE;
      S_CONV:  w_next_state = (r_cnt == 2'd3) ? S_DONE : S_CONV;
      S_DONE:  w_next_state = start ? S_CONV : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_CONV:  busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_digits <= 16'd0;
      r_acc    <= 14'd0;
      r_cnt    <= 2'd0;
      r_binary <= 12'd0;
      r_ovf    <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      r_bad    <= 1'b0;
      r_err    <= 1'b0;
`endif
    end else begin
      if (w_load) begin
        r_digits <= {tho, hun, ten, one};
        r_acc    <= 14'd0;
        r_cnt    <= 2'd0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        r_bad    <= w_bad;
`endif
      end else if (r_state == S_CONV) begin
        r_acc <= w_acc_next[13:0];
        r_cnt <= r_cnt + 2'd1;
      end
      if (w_last) begin
        r_binary <= w_res_bin;
        r_ovf    <= w_res_ovf;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        r_err    <= r_bad;
`endif
      end
    end
  end

  assign binary = r_binary;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed scenarios plus randomized conversions against an arithmetic model.
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  tho = 4'd0;
  logic [3:0]  hun = 4'd0;
  logic [3:0]  ten = 4'd0;
  logic [3:0]  one = 4'd0;
  logic [11:0] binary;
  logic        done;
  logic        busy;
  logic        ovf;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_to_bin dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .tho(tho), .hun(hun), .ten(ten), .one(one),
    .binary(binary), .done(done), .busy(busy), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1);
  end

  // Reference: decimal value from the digit weights, then saturate or flag invalid digits.
  function automatic void model(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                                input logic [3:0] d, output logic [11:0] e_bin,
                                output logic e_ovf, output logic e_err);
    int  v;
    bit  bad;
    v   = int'(a) * 1000 + int'(b) * 100 + int'(c) * 10 + int'(d);
    bad = (a > 9) || (b > 9) || (c > 9) || (d > 9);
    e_err = 1'b0;
    if (v > 4095) begin e_bin = 12'hFFF; e_ovf = 1'b1; end
    else          begin e_bin = 12'(v);  e_ovf = 1'b0; end
`ifdef BCD2BIN_DIGIT_CHECK_EN
    if (bad) begin e_bin = 12'd0; e_ovf = 1'b0; e_err = 1'b1; end
`else
    if (bad) e_err = 1'b0;
`endif
  endfunction

  // Start at the next edge, scramble inputs afterwards, check busy/done timing and the result.
  task automatic run_conv(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic [3:0] d, input string name);
    logic [11:0] e_bin;
    logic        e_ovf, e_err;
    model(a, b, c, d, e_bin, e_ovf, e_err);
    tho = a; hun = b; ten = c; one = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tho = 4'($urandom); hun = 4'($urandom); ten = 4'($urandom); one = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({busy, done} !== 2'b10) begin
        n_fail++;
        $display("FAIL %s busy/done cycle %0d: got busy=%b done=%b, required busy=1 done=0", name, i, busy, done);
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if ({busy, done, binary, ovf, err} !== {2'b01, e_bin, e_ovf, e_err}) begin
      n_fail++;
      $display("FAIL %s result: got busy=%b done=%b binary=%0d ovf=%b err=%b, required busy=0 done=1 binary=%0d ovf=%b err=%b",
               name, busy, done, binary, ovf, err, e_bin, e_ovf, e_err);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({binary, done, busy, ovf, err} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got binary=%0d done=%b busy=%b ovf=%b err=%b, required all 0", binary, done, busy, ovf, err);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({binary, done, busy, ovf, err} !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: got binary=%0d done=%b busy=%b ovf=%b err=%b, required all 0", i, binary, done, busy, ovf, err);
      end
    end
  endtask

  task automatic test_basic();
    run_conv(4'd4, 4'd0, 4'd9, 4'd5, "max_4095");
  endtask

  task automatic test_hold();
    logic [11:0] e_bin;
    logic        e_ovf, e_err;
    run_conv(4'd0, 4'd8, 4'd6, 4'd1, "hold_setup");
    model(4'd0, 4'd8, 4'd6, 4'd1, e_bin, e_ovf, e_err);
    for (int i = 0; i < 4; i++) begin
      tho = 4'($urandom); hun = 4'($urandom); ten = 4'($urandom); one = 4'($urandom);
      @(posedge clk); #1;
      n_tests++;
      if ({busy, done, binary, ovf, err} !== {2'b00, e_bin, e_ovf, e_err}) begin
        n_fail++;
        $display("FAIL hold cycle %0d: got busy=%b done=%b binary=%0d ovf=%b err=%b, required busy=0 done=0 binary=%0d ovf=%b err=%b",
                 i, busy, done, binary, ovf, err, e_bin, e_ovf, e_err);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_conv(4'd0, 4'd1, 4'd2, 4'd3, "b2b_first");
    run_conv(4'd9, 4'd9, 4'd9, 4'd9, "b2b_second_sat");
  endtask

  task automatic test_invalid_digit();
    run_conv(4'd1, 4'hA, 4'd0, 4'd0, "invalid_digit");
    run_conv(4'd0, 4'd0, 4'd4, 4'd2, "valid_after_invalid");
  endtask

  task automatic test_ignore_start();
    tho = 4'd2; hun = 4'd5; ten = 4'd0; one = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; tho = 4'd7; hun = 4'd7; ten = 4'd7; one = 4'd7;
    @(posedge clk); #1;
    start = 1'b0; tho = 4'd1; hun = 4'd1; ten = 4'd1; one = 4'd1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({done, binary, ovf} !== {1'b1, 12'd2500, 1'b0}) begin
      n_fail++;
      $display("FAIL ignore_start result: got done=%b binary=%0d ovf=%b, required done=1 binary=2500 ovf=0", done, binary, ovf);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL ignore_start after: got busy=%b done=%b, required busy=0 done=0", busy, done);
    end
  endtask

  task automatic test_reset_mid_conv();
    tho = 4'd3; hun = 4'd3; ten = 4'd3; one = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({binary, busy, done, ovf, err} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_conv async: got binary=%0d busy=%b done=%b ovf=%b err=%b, required all 0", binary, busy, done, ovf, err);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 1) reset_n = 1'b1;
      n_tests++;
      if ({binary, done} !== 13'd0) begin
        n_fail++;
        $display("FAIL reset_mid_conv cycle %0d: got binary=%0d done=%b, required binary=0 done=0", i, binary, done);
      end
    end
    run_conv(4'd0, 4'd0, 4'd0, 4'd7, "after_reset_7");
  endtask

  task automatic test_random();
    logic [3:0] d [4];
    for (int n = 0; n < 40; n++) begin
      for (int j = 0; j < 4; j++)
        d[j] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      run_conv(d[0], d[1], d[2], d[3], "random");
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_back_to_back();
    test_invalid_digit();
    test_ignore_start();
    test_reset_mid_conv();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
